// File: rtl/axis_packet_fifo_writer_pkg.sv
// upb_axis_pkg: shared types and constants for the packet FIFO writer.
// Holds the writer FSM state type, counter saturation limit and MAX_BEATS range.
package upb_axis_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DISCARD
  } wr_state_t;

  // All-ones pattern; counters of up to 64 bits slice their limit from it.
  localparam logic [63:0] SAT_ONES = '1;

  localparam int unsigned MAX_BEATS_MIN = 2;
  localparam int unsigned MAX_BEATS_MAX = 65535;

endpackage

// File: rtl/axis_packet_fifo_writer_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports: clk, rst_n (sync, active-low), inc (count enable), count (value).
module sat_counter
  import upb_axis_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LIMIT = SAT_ONES[W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axis_packet_fifo_writer.sv
// axis_packet_fifo_writer: AXI4-Stream ingress feeding a packet FIFO write port.
// Drops, truncates (dirty) or back-pressures packets to protect the FIFO.
// Ports: axi_aclk/axi_resetn (sync active-low); s_axis_* AXI4-Stream slave;
//   wr/wr_data/wr_metadata/wr_last/wr_dirty registered FIFO write port;
//   wr_full/wr_almost_full FIFO status; pkt/drop/trunc_count saturating
//   statistics; overflow_error sticky flag for a write into a full FIFO.
module axis_packet_fifo_writer
  import upb_axis_pkg::*;
#(
  parameter int DATA_WIDTH     = 256,
  parameter int METADATA_WIDTH = 32,
  parameter int DROP_MODE      = 1,
  parameter int MAX_BEATS      = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      axi_aclk,
  input  logic                      axi_resetn,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [METADATA_WIDTH-1:0] s_axis_tuser,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic                      wr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [METADATA_WIDTH-1:0] wr_metadata,
  output logic                      wr_last,
  output logic                      wr_dirty,
  input  logic                      wr_full,
  input  logic                      wr_almost_full,
  output logic [CNT_WIDTH-1:0]      pkt_count,
  output logic [CNT_WIDTH-1:0]      drop_count,
  output logic [CNT_WIDTH-1:0]      trunc_count,
  output logic                      overflow_error
);

  if ((MAX_BEATS < MAX_BEATS_MIN) || (MAX_BEATS > MAX_BEATS_MAX)) begin : g_bad
    $error("MAX_BEATS out of range");
  end

  localparam logic [15:0] LEN_LIMIT = 16'(MAX_BEATS - 1);
  localparam logic        DROP      = (DROP_MODE != 0);

  wr_state_t   state, state_d;
  logic [15:0] beat_cnt, beat_cnt_d;
  logic        accept, congest;
  logic        wr_d, last_d, dirty_d;
  logic        pkt_inc, drop_inc, trunc_inc;

  assign s_axis_tready = axi_resetn & (DROP | ~wr_almost_full);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign congest       = DROP & wr_almost_full;

  always_comb begin
    state_d    = state;
    beat_cnt_d = beat_cnt;
    wr_d       = 1'b0;
    last_d     = 1'b0;
    dirty_d    = 1'b0;
    pkt_inc    = 1'b0;
    drop_inc   = 1'b0;
    trunc_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        beat_cnt_d = '0;
        if (accept) begin
          if (congest) begin
            drop_inc = 1'b1;
            if (!s_axis_tlast) state_d = DISCARD;
          end else begin
            wr_d       = 1'b1;
            last_d     = s_axis_tlast;
            beat_cnt_d = 16'd1;
            if (s_axis_tlast) pkt_inc = 1'b1;
            else              state_d = PASS;
          end
        end
      end
      PASS: begin
        if (accept) begin
          wr_d       = 1'b1;
          beat_cnt_d = beat_cnt + 16'd1;
          if (s_axis_tlast) begin
            // A clean tail is always written, even under almost_full.
            last_d  = 1'b1;
            pkt_inc = 1'b1;
            state_d = IDLE;
          end else if (congest || (beat_cnt == LEN_LIMIT)) begin
            // Close the packet early and mark it for discard by the reader.
            last_d    = 1'b1;
            dirty_d   = 1'b1;
            trunc_inc = 1'b1;
            state_d   = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (accept && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      wr             <= 1'b0;
      wr_last        <= 1'b0;
      wr_dirty       <= 1'b0;
      wr_data        <= '0;
      wr_metadata    <= '0;
      overflow_error <= 1'b0;
    end else begin
      state    <= state_d;
      beat_cnt <= beat_cnt_d;
      wr       <= wr_d;
      wr_last  <= last_d;
      wr_dirty <= dirty_d;
      if (wr_d) wr_data <= s_axis_tdata;
      // Metadata is latched at packet start and held for every later beat.
      if (wr_d && (state == IDLE)) wr_metadata <= s_axis_tuser;
      if (wr && wr_full) overflow_error <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_pkt_cnt (
    .clk   (axi_aclk),
    .rst_n (axi_resetn),
    .inc   (pkt_inc),
    .count (pkt_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_drop_cnt (
    .clk   (axi_aclk),
    .rst_n (axi_resetn),
    .inc   (drop_inc),
    .count (drop_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_trunc_cnt (
    .clk   (axi_aclk),
    .rst_n (axi_resetn),
    .inc   (trunc_inc),
    .count (trunc_count)
  );

endmodule

// File: tb/tb_axis_packet_fifo_writer.sv
// Bench for axis_packet_fifo_writer: drop-mode and back-pressure instances.
// Expected writes are queued on acceptance and matched against wr output.
module tb_axis_packet_fifo_writer;

  localparam int DW = 32;
  localparam int MW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [DW-1:0] tdata;
  logic [MW-1:0] tuser;
  logic          tvalid, tlast, af, full;

  logic          rdy_a, wr_a, last_a, dirty_a, ovf_a;
  logic [DW-1:0] data_a;
  logic [MW-1:0] meta_a;
  logic [CW-1:0] pkt_a, drop_a, trunc_a;

  logic          rdy_b, wr_b, last_b, dirty_b, ovf_b;
  logic [DW-1:0] data_b;
  logic [MW-1:0] meta_b;
  logic [CW-1:0] pkt_b, drop_b, trunc_b;

  axis_packet_fifo_writer #(
    .DATA_WIDTH(DW), .METADATA_WIDTH(MW), .DROP_MODE(1),
    .MAX_BEATS(4), .CNT_WIDTH(CW)
  ) u_dut_a (
    .axi_aclk(clk), .axi_resetn(rstn),
    .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(rdy_a),
    .wr(wr_a), .wr_data(data_a), .wr_metadata(meta_a),
    .wr_last(last_a), .wr_dirty(dirty_a),
    .wr_full(full), .wr_almost_full(af),
    .pkt_count(pkt_a), .drop_count(drop_a),
    .trunc_count(trunc_a), .overflow_error(ovf_a)
  );

  axis_packet_fifo_writer #(
    .DATA_WIDTH(DW), .METADATA_WIDTH(MW), .DROP_MODE(0),
    .MAX_BEATS(64), .CNT_WIDTH(CW)
  ) u_dut_b (
    .axi_aclk(clk), .axi_resetn(rstn),
    .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(rdy_b),
    .wr(wr_b), .wr_data(data_b), .wr_metadata(meta_b),
    .wr_last(last_b), .wr_dirty(dirty_b),
    .wr_full(full), .wr_almost_full(af),
    .pkt_count(pkt_b), .drop_count(drop_b),
    .trunc_count(trunc_b), .overflow_error(ovf_b)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    logic          l;
    logic          y;
    int            due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int tc;
  logic sel, tog_en;
  logic e_wr, e_last, e_dirty;
  logic [MW-1:0] e_meta;
  logic [DW-1:0] dcnt;

  logic          rdy_s, wr_s, last_s, dirty_s;
  logic [DW-1:0] data_s;
  logic [MW-1:0] meta_s;
  assign rdy_s   = sel ? rdy_b   : rdy_a;
  assign wr_s    = sel ? wr_b    : wr_a;
  assign last_s  = sel ? last_b  : last_a;
  assign dirty_s = sel ? dirty_b : dirty_a;
  assign data_s  = sel ? data_b  : data_a;
  assign meta_s  = sel ? meta_b  : meta_a;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_s) begin
      if (q.size() == 0) begin
        chk("spurious_wr", 64'(1), 64'(0));
      end else begin
        mon_e = q.pop_front();
        chk("wr_data", 64'(data_s), 64'(mon_e.d));
        chk("wr_meta", 64'(meta_s), 64'(mon_e.m));
        chk("wr_last", 64'(last_s), 64'(mon_e.l));
        chk("wr_dirty", 64'(dirty_s), 64'(mon_e.y));
        chk("wr_latency", 64'(cyc), 64'(mon_e.due));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      void'(q.pop_front());
      chk("missing_wr", 64'(0), 64'(1));
    end
    if (sel && rstn) chk("tready", 64'(rdy_b), 64'(!af));
    if (tvalid && rdy_s && e_wr) begin
      mon_e.d   = tdata;
      mon_e.m   = e_meta;
      mon_e.l   = e_last;
      mon_e.y   = e_dirty;
      mon_e.due = cyc + 1;
      q.push_back(mon_e);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      tick;
      if (tog_en) begin
        tc++;
        if (tc == 3) begin
          af = ~af;
          tc = 0;
        end
      end
    end
  end

  task automatic beat(input logic [MW-1:0] u, input logic lst,
                      input logic ew, input logic el, input logic ed,
                      input logic [MW-1:0] em);
    int w;
    tdata   = dcnt;
    dcnt    = dcnt + 1;
    tuser   = u;
    tlast   = lst;
    tvalid  = 1'b1;
    e_wr    = ew;
    e_last  = el;
    e_dirty = ed;
    e_meta  = em;
    w = 0;
    @(negedge clk);
    while (!rdy_s && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) chk("beat_timeout", 64'(0), 64'(1));
    tick;
    tvalid = 1'b0;
    e_wr   = 1'b0;
  endtask

  task automatic pkt(input int n, input logic [MW-1:0] u, input int wr_n,
                     input logic dty, input int af_at);
    for (int i = 1; i <= n; i++) begin
      if (!tog_en) af = (af_at != 0) && (i >= af_at);
      beat((i == 1) ? u : ~u, i == n, i <= wr_n, i == wr_n,
           dty && (i == wr_n), u);
    end
  endtask

  task automatic drain;
    repeat (4) tick;
    chk("queue_drained", 64'(q.size()), 64'(0));
  endtask

  task automatic cnt_chk(input string tag, input int p, input int d,
                         input int t);
    chk({tag, "_pkt"},   64'(sel ? pkt_b : pkt_a),     64'(p));
    chk({tag, "_drop"},  64'(sel ? drop_b : drop_a),   64'(d));
    chk({tag, "_trunc"}, 64'(sel ? trunc_b : trunc_a), 64'(t));
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_wr"},    64'(wr_a),    64'(0));
    chk({tag, "_last"},  64'(last_a),  64'(0));
    chk({tag, "_dirty"}, 64'(dirty_a), 64'(0));
    chk({tag, "_data"},  64'(data_a),  64'(0));
    chk({tag, "_meta"},  64'(meta_a),  64'(0));
    chk({tag, "_ovf"},   64'(ovf_a),   64'(0));
    chk({tag, "_rdy_a"}, 64'(rdy_a),   64'(0));
    chk({tag, "_rdy_b"}, 64'(rdy_b),   64'(0));
    chk({tag, "_wr_b"},  64'(wr_b),    64'(0));
    cnt_chk(tag, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    tdata = '0; tuser = '0; af = 1'b0; full = 1'b0;
    sel = 1'b0; tog_en = 1'b0; tc = 0;
    e_wr = 1'b0; e_last = 1'b0; e_dirty = 1'b0; e_meta = '0;
    dcnt = 32'h100;
    repeat (3) tick;
    rst_chk("reset");
    rstn = 1'b1;
    tick;

    pkt(3, 16'h0011, 3, 1'b0, 0);
    pkt(1, 16'h0022, 1, 1'b0, 0);
    pkt(3, 16'h0033, 3, 1'b0, 0);
    drain;
    cnt_chk("clean", 3, 0, 0);

    pkt(4, 16'h0044, 0, 1'b0, 1);
    pkt(2, 16'h0055, 2, 1'b0, 0);
    drain;
    cnt_chk("drop", 4, 1, 0);

    pkt(6, 16'h0066, 3, 1'b1, 3);
    pkt(1, 16'h0077, 1, 1'b0, 0);
    pkt(2, 16'h0088, 2, 1'b0, 2);
    drain;
    cnt_chk("trunc", 6, 1, 1);

    pkt(10, 16'h0099, 4, 1'b1, 0);
    pkt(4, 16'h00AA, 4, 1'b0, 0);
    drain;
    cnt_chk("maxlen", 7, 1, 2);

    chk("ovf_before", 64'(ovf_a), 64'(0));
    full = 1'b1;
    pkt(1, 16'h00BB, 1, 1'b0, 0);
    tick;
    tick;
    full = 1'b0;
    chk("ovf_set", 64'(ovf_a), 64'(1));
    repeat (5) tick;
    chk("ovf_sticky", 64'(ovf_a), 64'(1));
    cnt_chk("ovf", 8, 1, 2);

    af = 1'b0;
    beat(16'h00C0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00C0);
    beat(16'hFF3F, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00C0);
    rstn = 1'b0;
    tick;
    rst_chk("midpkt");
    chk("midpkt_queue", 64'(q.size()), 64'(0));
    rstn = 1'b1;
    tick;
    pkt(2, 16'h00C5, 2, 1'b0, 0);
    drain;
    cnt_chk("after_rst", 1, 0, 0);

    sel = 1'b1;
    rstn = 1'b0;
    repeat (2) tick;
    rstn = 1'b1;
    tick;
    af = 1'b0;
    tc = 0;
    tog_en = 1'b1;
    pkt(20, 16'h00DD, 20, 1'b0, 0);
    tog_en = 1'b0;
    af = 1'b0;
    drain;
    cnt_chk("bp", 1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_packet_fifo_writer.md
Name: axis_packet_fifo_writer

Overview:
- Ingress stage directly upstream of the UPB simple packet FIFO.
- Accepts one AXI4-Stream packet stream and drives the FIFO write port: wr, wr_data, wr_metadata, wr_last and wr_dirty.
- Protects the FIFO from overflow: either back-pressures the source, or drops or truncates packets. A truncated packet is marked dirty so the FIFO read side discards it.
- Keeps saturating packet, drop and truncation statistics, plus a sticky overflow error flag.

Parameters:
- DATA_WIDTH, 256: tdata and wr_data width.
- METADATA_WIDTH, 32: tuser and wr_metadata width.
- DROP_MODE, 1: 1 = s_axis_tready is held high and congestion causes drop/truncate; 0 = congestion back-pressures the source.
- MAX_BEATS, 64: longest legal packet in beats; longer packets are truncated. Legal range 2..65535.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- axi_aclk  in  1  single clock; all logic on the rising edge.
- axi_resetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  beat data.
- s_axis_tuser  in  METADATA_WIDTH  packet metadata; sampled on the first beat of each packet.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  beat accept.
- wr  out  1  FIFO write strobe.
- wr_data  out  DATA_WIDTH  FIFO data.
- wr_metadata  out  METADATA_WIDTH  FIFO metadata.
- wr_last  out  1  FIFO last flag.
- wr_dirty  out  1  FIFO dirty flag; meaningful only with wr_last.
- wr_full  in  1  FIFO full.
- wr_almost_full  in  1  FIFO almost full.
- pkt_count  out  CNT_WIDTH  packets written complete and clean.
- drop_count  out  CNT_WIDTH  packets dropped entirely.
- trunc_count  out  CNT_WIDTH  packets truncated and written dirty.
- overflow_error  out  1  sticky: wr was asserted while wr_full was high.

Behaviour:
- Handshake:
  - Beat accepted when s_axis_tvalid & s_axis_tready.
  - DROP_MODE=1: s_axis_tready = 1 whenever out of reset.
  - DROP_MODE=0: s_axis_tready = ~wr_almost_full (combinational).
  - s_axis_tready = 0 while axi_resetn = 0.
- Output register:
  - All wr_* outputs are registered; an accepted beat appears on wr exactly 1 cycle later.
  - wr pulses for exactly one cycle per written beat.
  - The FIFO's almost_full slack (>= 2 entries) covers this one cycle of latency.
- Metadata:
  - tuser is captured on the first accepted beat of each packet.
  - The captured value is presented on wr_metadata for every beat of that packet.
  - This holds whether the FIFO commits metadata on the first or on the last beat.
- Beat counter:
  - 16 bits; cleared in IDLE; incremented on each beat accepted in PASS.
- FSM states IDLE, PASS, DISCARD:
  - IDLE, beat accepted, congestion (DROP_MODE=1 & wr_almost_full): no write; drop_count+1; go to DISCARD if ~tlast, else stay in IDLE.
  - IDLE, beat accepted, no congestion: write the beat (wr_last=tlast, wr_dirty=0); beat count = 1; go to PASS if ~tlast; if tlast, pkt_count+1 and stay in IDLE.
  - PASS, tlast beat: write it clean with wr_last=1; pkt_count+1; go to IDLE. A clean last beat is written even under almost_full.
  - PASS, non-last beat with congestion, or with beat count == MAX_BEATS-1: write the beat with wr_last=1 and wr_dirty=1; trunc_count+1; go to DISCARD.
  - PASS, any other beat: write normally.
  - DISCARD: consume beats with no write; on tlast go to IDLE.
- Single-beat packets are legal and are written with wr_last=1.
- Counters saturate at all-ones and never wrap.
- overflow_error is set when the registered wr=1 and wr_full=1 in the same cycle; it is cleared only by reset.
- Reset, including mid-packet:
  - Next edge: FSM = IDLE; beat count = 0; wr, wr_last, wr_dirty = 0; wr_data, wr_metadata = 0.
  - All counters = 0; overflow_error = 0.
  - A partially written packet is not terminated. The FIFO is reset by the same system reset.
  - The first beat accepted after reset is treated as a packet start.

Decomposition:
- Package upb_axis_pkg holds:
  - typedef wr_state_t {IDLE, PASS, DISCARD};
  - the counter saturation limit;
  - the MAX_BEATS range check constant.
- One sub-module, sat_counter: width-parameterised, with increment enable and synchronous active-low reset.
- sat_counter is instantiated 3 times, for pkt_count, drop_count and trunc_count.

Test Plan:
- Clean packets: DROP_MODE=1, wr_almost_full=0, packets of 3, 1 and 3 beats. Expect 7 wr pulses, each 1 cycle after its accepted beat; wr_last on beats 3, 4 and 7; wr_dirty=0 throughout; pkt_count=3; wr_metadata equal to each packet's first-beat tuser.
- Drop at start: DROP_MODE=1, wr_almost_full=1 at the first beat of a 4-beat packet. Expect no wr; drop_count=1. The next packet, with almost_full=0, is written normally.
- Truncate mid-packet: DROP_MODE=1, almost_full rises on beat 3 of a 6-beat packet. Expect beats 1-3 written, with beat 3 carrying wr_last=1 and wr_dirty=1; trunc_count=1; beats 4-6 not written; FSM in IDLE after beat 6.
- Length limit: MAX_BEATS=4, 10-beat packet. Expect 4 writes, the 4th with last=1 and dirty=1; trunc_count=1. A 4-beat packet is written clean.
- Back-pressure: DROP_MODE=0, toggle wr_almost_full every 3 cycles over a 20-beat packet. Expect s_axis_tready = ~wr_almost_full; all 20 beats written in order; no dirty flag; drop_count = trunc_count = 0.
- Reset and errors: assert axi_resetn=0 mid-packet, then release. Expect all outputs 0 and the next beat treated as a first beat. Separately force wr_full=1 during a write: expect overflow_error=1, sticky until reset.
